multicycle_ctrl: RTL and testbench

Control FSM for the multi-cycle build of the MIPS-subset CPU. It sequences a shared datapath: one memory port, one ALU, IR/aluOut/MDR holding registers and the register file. The block decodes the latched instruction and drives every enable and mux select, one microstep per clock. It stalls on a memory ready handshake and halts permanently on an illegal instruction.

---
 rtl/multicycle_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS-subset CPU: sequences one memory port,
// one ALU and the register file, one microstep per clock.
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             aluZero,
    input  logic             aluOverflow,
    input  logic             memReady,
    output logic             memReq,
    output logic             memAddrSel,
    output logic             dmWe,
    output logic             irWe,
    output logic             pcWe,
    output logic [1:0]       pcSrcCtrl,
    output logic             regWe,
    output logic [1:0]       regWAddrSel,
    output logic [1:0]       regDInCtrl,
    output logic             aluASel,
    output logic [1:0]       aluBSel,
    output logic [2:0]       aluOp,
    output logic             halted,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        JR       = 4'd11,
        JAL      = 4'd12,
        HALT     = 4'd15
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic       mem_req_c, mem_addr_sel_c, dm_we_c, ir_we_c, pc_we_c, reg_we_c, alu_a_sel_c;
    logic [1:0] pc_src_c, reg_waddr_c, reg_din_c, alu_b_sel_c;
    logic [2:0] alu_op_c;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mem_req_c      = 1'b0;
        mem_addr_sel_c = 1'b0;
        dm_we_c        = 1'b0;
        ir_we_c        = 1'b0;
        pc_we_c        = 1'b0;
        pc_src_c       = 2'd0;
        reg_we_c       = 1'b0;
        reg_waddr_c    = 2'd0;
        reg_din_c      = 2'd0;
        alu_a_sel_c    = 1'b0;
        alu_b_sel_c    = 2'd0;
        alu_op_c       = 3'd0;

        case (state_q)
            FETCH: begin
                mem_req_c   = 1'b1;
                alu_b_sel_c = 2'd1;
                if (memReady) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // Speculative branch target pc+4+(imm<<2) lands in aluOut
                alu_b_sel_c = 2'd3;
                case (opcode)
                    6'h00: begin
                        case (funct)
                            6'h20, 6'h22, 6'h2A: state_d = EXEC_R;
                            6'h08:               state_d = JR;
                            default:             state_d = HALT;
                        endcase
                    end
                    6'h02:        state_d = JUMP;
                    6'h03:        state_d = JAL;
                    6'h05:        state_d = BRANCH;
                    6'h08, 6'h0E: state_d = EXEC_I;
                    6'h23, 6'h2B: state_d = MEM_ADDR;
                    default:      state_d = HALT;
                endcase
            end
            EXEC_R: begin
                alu_a_sel_c = 1'b1;
                case (funct)
                    6'h22:   alu_op_c = 3'd1;
                    6'h2A:   alu_op_c = 3'd3;
                    default: alu_op_c = 3'd0;
                endcase
                state_d = WB_ALU;
            end
            EXEC_I: begin
                alu_a_sel_c = 1'b1;
                alu_b_sel_c = 2'd2;
                alu_op_c    = (opcode == 6'h0E) ? 3'd2 : 3'd0;
                state_d     = WB_ALU;
            end
            WB_ALU: begin
                reg_we_c    = 1'b1;
                reg_waddr_c = (opcode == 6'h00) ? 2'd1 : 2'd0;
                state_d     = FETCH;
            end
            MEM_ADDR: begin
                alu_a_sel_c = 1'b1;
                alu_b_sel_c = 2'd2;
                state_d     = (opcode == 6'h2B) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_req_c      = 1'b1;
                mem_addr_sel_c = 1'b1;
                if (memReady) state_d = WB_MEM;
            end
            WB_MEM: begin
                reg_we_c  = 1'b1;
                reg_din_c = 2'd1;
                state_d   = FETCH;
            end
            MEM_WR: begin
                mem_req_c      = 1'b1;
                mem_addr_sel_c = 1'b1;
                dm_we_c        = 1'b1;
                if (memReady) state_d = FETCH;
            end
            BRANCH: begin
                // BNE: taken unless the subtraction is a genuine zero
                alu_a_sel_c = 1'b1;
                alu_op_c    = 3'd1;
                pc_src_c    = 2'd3;
                pc_we_c     = ~(aluZero & ~aluOverflow);
                state_d     = FETCH;
            end
            JUMP: begin
                pc_we_c  = 1'b1;
                pc_src_c = 2'd1;
                state_d  = FETCH;
            end
            JR: begin
                pc_we_c  = 1'b1;
                pc_src_c = 2'd2;
                state_d  = FETCH;
            end
            JAL: begin
                pc_we_c     = 1'b1;
                pc_src_c    = 2'd1;
                reg_we_c    = 1'b1;
                reg_waddr_c = 2'd2;
                reg_din_c   = 2'd2;
                state_d     = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase

        retired_d = retired_q;
        if (state_d == FETCH && state_q != FETCH)
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Every output is held at zero while reset is asserted, independent of the clock
    assign memReq      = rstN & mem_req_c;
    assign memAddrSel  = rstN & mem_addr_sel_c;
    assign dmWe        = rstN & dm_we_c;
    assign irWe        = rstN & ir_we_c;
    assign pcWe        = rstN & pc_we_c;
    assign regWe       = rstN & reg_we_c;
    assign aluASel     = rstN & alu_a_sel_c;
    assign pcSrcCtrl   = rstN ? pc_src_c    : 2'd0;
    assign regWAddrSel = rstN ? reg_waddr_c : 2'd0;
    assign regDInCtrl  = rstN ? reg_din_c   : 2'd0;
    assign aluBSel     = rstN ? alu_b_sel_c : 2'd0;
    assign aluOp       = rstN ? alu_op_c    : 3'd0;
    assign halted      = rstN & (state_q == HALT);
    assign state       = state_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: instruction-level reference model builds
// the expected microstep path and per-step control word.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;
    localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_EXEC_I = 3, S_MEM_ADDR = 4,
                   S_MEM_RD = 5, S_MEM_WR = 6, S_WB_ALU = 7, S_WB_MEM = 8, S_BRANCH = 9,
                   S_JUMP = 10, S_JR = 11, S_JAL = 12, S_HALT = 15;

    logic             clk, rstN;
    logic [5:0]       opcode, funct;
    logic             aluZero, aluOverflow, memReady;
    logic             memReq, memAddrSel, dmWe, irWe, pcWe, regWe, aluASel, halted;
    logic [1:0]       pcSrcCtrl, regWAddrSel, regDInCtrl, aluBSel;
    logic [2:0]       aluOp;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    int n_cmp = 0;
    int n_mis = 0;
    int model_ret = 0;
    logic [5:0] cur_op, cur_fn;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rstN(rstN), .opcode(opcode), .funct(funct),
        .aluZero(aluZero), .aluOverflow(aluOverflow), .memReady(memReady),
        .memReq(memReq), .memAddrSel(memAddrSel), .dmWe(dmWe), .irWe(irWe),
        .pcWe(pcWe), .pcSrcCtrl(pcSrcCtrl), .regWe(regWe), .regWAddrSel(regWAddrSel),
        .regDInCtrl(regDInCtrl), .aluASel(aluASel), .aluBSel(aluBSel), .aluOp(aluOp),
        .halted(halted), .state(state), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [18:0] obs_vec();
        return {memReq, memAddrSel, dmWe, irWe, pcWe, pcSrcCtrl, regWe, regWAddrSel,
                regDInCtrl, aluASel, aluBSel, aluOp, halted};
    endfunction

    // Control word each microstep must present, straight from the state table
    function automatic logic [18:0] exp_out(input int st, input logic [5:0] op, input logic [5:0] fn,
                                            input logic rdy, input logic z, input logic ov);
        logic mr = 0, mas = 0, dw = 0, iw = 0, pw = 0, rw = 0, asel = 0, h = 0;
        logic [1:0] ps = 0, wa = 0, di = 0, bsel = 0;
        logic [2:0] aop = 0;
        case (st)
            S_FETCH:    begin mr = 1; bsel = 1; iw = rdy; pw = rdy; end
            S_DECODE:   bsel = 3;
            S_EXEC_R:   begin asel = 1; aop = (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd0; end
            S_EXEC_I:   begin asel = 1; bsel = 2; aop = (op == 6'h0E) ? 3'd2 : 3'd0; end
            S_WB_ALU:   begin rw = 1; wa = (op == 6'h00) ? 2'd1 : 2'd0; end
            S_MEM_ADDR: begin asel = 1; bsel = 2; end
            S_MEM_RD:   begin mr = 1; mas = 1; end
            S_WB_MEM:   begin rw = 1; di = 1; end
            S_MEM_WR:   begin mr = 1; mas = 1; dw = 1; end
            S_BRANCH:   begin asel = 1; aop = 1; ps = 3; pw = !(z && !ov); end
            S_JUMP:     begin pw = 1; ps = 1; end
            S_JR:       begin pw = 1; ps = 2; end
            S_JAL:      begin pw = 1; ps = 1; rw = 1; wa = 2; di = 2; end
            S_HALT:     h = 1;
            default:    h = 0;
        endcase
        return {mr, mas, dw, iw, pw, ps, rw, wa, di, asel, bsel, aop, h};
    endfunction

    // One clock: entered at posedge+1, checks at negedge, leaves at next posedge+1
    task automatic step(input int st, input int rdy, input int zsel);
        logic r, z, ov;
        r = (rdy == 2) ? logic'($urandom_range(1, 0)) : (rdy == 1);
        if (zsel < 0) begin
            z  = logic'($urandom_range(1, 0));
            ov = logic'($urandom_range(1, 0));
        end else begin
            z  = zsel[1];
            ov = zsel[0];
        end
        memReady = r; aluZero = z; aluOverflow = ov;
        @(negedge clk);
        chk("state", 32'(state), 32'(st));
        chk("ctrl", 32'(obs_vec()), 32'(exp_out(st, cur_op, cur_fn, r, z, ov)));
        if (st == S_HALT) chk("retired_frozen", 32'(retired), 32'(model_ret % (1 << CNT_W)));
        @(posedge clk);
        #1;
    endtask

    // Expected microstep path derived from the instruction class and wait-state counts
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                             input int wm, input int zsel);
        int st_q[$];
        int rd_q[$];
        bit illegal = 0;
        cur_op = op; cur_fn = fn; opcode = op; funct = fn;
        repeat (wf) begin st_q.push_back(S_FETCH); rd_q.push_back(0); end
        st_q.push_back(S_FETCH);  rd_q.push_back(1);
        st_q.push_back(S_DECODE); rd_q.push_back(2);
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin
            st_q.push_back(S_EXEC_R); st_q.push_back(S_WB_ALU); rd_q.push_back(2); rd_q.push_back(2);
        end else if (op == 6'h00 && fn == 6'h08) begin
            st_q.push_back(S_JR); rd_q.push_back(2);
        end else if (op == 6'h08 || op == 6'h0E) begin
            st_q.push_back(S_EXEC_I); st_q.push_back(S_WB_ALU); rd_q.push_back(2); rd_q.push_back(2);
        end else if (op == 6'h23 || op == 6'h2B) begin
            int ms = (op == 6'h23) ? S_MEM_RD : S_MEM_WR;
            st_q.push_back(S_MEM_ADDR); rd_q.push_back(2);
            repeat (wm) begin st_q.push_back(ms); rd_q.push_back(0); end
            st_q.push_back(ms); rd_q.push_back(1);
            if (op == 6'h23) begin st_q.push_back(S_WB_MEM); rd_q.push_back(2); end
        end else if (op == 6'h02) begin
            st_q.push_back(S_JUMP); rd_q.push_back(2);
        end else if (op == 6'h03) begin
            st_q.push_back(S_JAL); rd_q.push_back(2);
        end else if (op == 6'h05) begin
            st_q.push_back(S_BRANCH); rd_q.push_back(2);
        end else begin
            illegal = 1;
            repeat (20) begin st_q.push_back(S_HALT); rd_q.push_back(2); end
        end
        foreach (st_q[i]) step(st_q[i], rd_q[i], zsel);
        if (!illegal) begin
            model_ret++;
            chk("retired", 32'(retired), 32'(model_ret % (1 << CNT_W)));
        end
    endtask

    task automatic rand_instr();
        logic [5:0] ops [11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h05, 6'h08, 6'h0E, 6'h23, 6'h2B};
        logic [5:0] fns [4]  = '{6'h20, 6'h22, 6'h2A, 6'h08};
        int k = $urandom_range(10, 0);
        logic [5:0] fn = (k < 4) ? fns[k] : 6'($urandom);
        run_instr(ops[k], fn, $urandom_range(2, 0), $urandom_range(2, 0), -1);
    endtask

    initial begin
        rstN = 1'b0; memReady = 1'b1; aluZero = 1'b0; aluOverflow = 1'b0;
        opcode = 6'h00; funct = 6'h20; cur_op = 6'h00; cur_fn = 6'h20;
        #3;
        chk("rst_ctrl", 32'(obs_vec()), 32'd0);
        chk("rst_state", 32'(state), 32'(S_FETCH));
        chk("rst_retired", 32'(retired), 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;

        run_instr(6'h00, 6'h20, 0, 0, -1);            // ADD
        run_instr(6'h23, 6'h11, 2, 2, -1);            // LW with waits
        run_instr(6'h05, 6'h00, 0, 0, 0);             // BNE taken (zero=0)
        run_instr(6'h05, 6'h00, 0, 0, 2);             // BNE not taken
        run_instr(6'h05, 6'h00, 1, 0, 3);             // BNE taken on overflow
        run_instr(6'h03, 6'h15, 0, 0, -1);            // JAL
        run_instr(6'h2B, 6'h00, 1, 3, -1);            // SW with waits
        repeat (40) rand_instr();

        run_instr(6'h3F, 6'h00, 0, 0, -1);            // illegal opcode
        #2 rstN = 1'b0;
        #1;
        chk("halt_rst_halted", 32'(halted), 32'd0);
        chk("halt_rst_state", 32'(state), 32'(S_FETCH));
        chk("halt_rst_retired", 32'(retired), 32'd0);
        model_ret = 0;
        @(posedge clk); #1;
        rstN = 1'b1;

        run_instr(6'h00, 6'h00, 0, 0, -1);            // illegal funct under opcode 0
        #2 rstN = 1'b0;
        #1;
        chk("halt2_rst_ctrl", 32'(obs_vec()), 32'd0);
        model_ret = 0;
        @(posedge clk); #1;
        rstN = 1'b1;

        repeat (5) rand_instr();
        cur_op = 6'h2B; cur_fn = 6'h00; opcode = 6'h2B; funct = 6'h00;
        step(S_FETCH, 1, -1);
        step(S_DECODE, 2, -1);
        step(S_MEM_ADDR, 2, -1);
        memReady = 1'b0;
        @(negedge clk);
        chk("memwr_state", 32'(state), 32'(S_MEM_WR));
        chk("memwr_dmwe", 32'(dmWe), 32'd1);
        rstN = 1'b0;
        #1;
        chk("memwr_rst_ctrl", 32'(obs_vec()), 32'd0);
        chk("memwr_rst_state", 32'(state), 32'(S_FETCH));
        chk("memwr_rst_retired", 32'(retired), 32'd0);
        model_ret = 0;
        @(posedge clk); #1;
        rstN = 1'b1;

        repeat (16) rand_instr();                     // retired wraps back to 0
        chk("wrap", 32'(retired), 32'd0);
        repeat (60) rand_instr();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
